serial_frame_tx: RTL and testbench

Parametrised, multi-character UART transmitter that serialises a latched byte buffer onto `TXD` under a four-phase `START`/`END` handshake. It is the next-generation serial output stage for the search engines: a result word (for example a recovered password) is handed over in one cycle and shipped out as a framed 8-bit character stream. It adds a runtime baud divisor, optional parity, one or two stop bits, bit-order selection, an optional CR LF trailer and an abort path.

---
 rtl/serial_tx_pkg.sv | 33 +++
 rtl/serial_baud_tick.sv | 44 ++++
 rtl/serial_frame_tx.sv | 231 +++++++++++++++++++++++
 tb/tb_serial_frame_tx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// ============================================================================
//  serial_tx_pkg
//  Shared types and constants for the framed serial transmitter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STARTB = 3'd1,
    ST_DATA   = 3'd2,
    ST_PAR    = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;

  // Bits per character: start + 8 data + optional parity + stop bits.
  function automatic int frame_bits(input int parity, input int stop);
    return 10 + ((parity != PAR_NONE) ? 1 : 0) + (stop - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_baud_tick.sv
// ============================================================================
//  serial_baud_tick
//  Loadable bit-period down-counter; ticks once at the end of each bit.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module serial_baud_tick #(
  parameter int DIV_W = 12
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_load,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_period,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_period;
  logic [DIV_W-1:0] r_count;

  // The period is captured together with the first load so later
  // changes on the divisor input cannot disturb a running transfer.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_period <= '0;
      r_count  <= '0;
    end else if (i_load) begin
      r_period <= i_period;
      r_count  <= i_period;
    end else if (i_run) begin
      if (r_count == '0) begin
        r_count <= r_period;
      end else begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_tick = i_run && (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/serial_frame_tx.sv
// ============================================================================
//  serial_frame_tx
//  Multi-character UART transmitter with START/END four-phase handshake.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module serial_frame_tx
  import serial_tx_pkg::*;
#(
  parameter int BUFFLEN   = 10,
  parameter int DIV_W     = 12,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int LSB_FIRST = 1,
  parameter int TRAILER   = 0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   START,
  input  logic                   ABORT,
  input  logic [DIV_W-1:0]       DIVISOR,
  input  logic [8*BUFFLEN-1:0]   BUFFER,
  output logic                   TXD,
  output logic                   BUSY,
  output logic                   END,
  output logic                   ABORTED
);

  localparam int c_NUM_CHARS  = BUFFLEN + 2 * TRAILER;
  localparam int c_FRAME_BITS = frame_bits(PARITY, STOP_BITS);
  localparam int c_CHR_W      = 7;
  localparam int c_POS_W      = 4;

  localparam logic [c_POS_W-1:0] c_LAST_DATA_POS = 4'd8;
  localparam logic [c_POS_W-1:0] c_LAST_POS      = c_POS_W'(c_FRAME_BITS - 1);
  localparam logic [c_CHR_W-1:0] c_LAST_CHR      = c_CHR_W'(c_NUM_CHARS - 1);
  localparam logic               c_HAS_PAR       = (PARITY != PAR_NONE);
  localparam logic               c_ODD_PAR       = (PARITY == PAR_ODD);

  tx_state_t            r_state;
  tx_state_t            w_state_nxt;
  logic [c_POS_W-1:0]   r_pos;
  logic [c_POS_W-1:0]   w_pos_nxt;
  logic [c_CHR_W-1:0]   r_chr;
  logic [c_CHR_W-1:0]   w_chr_nxt;
  logic [8*BUFFLEN-1:0] r_buf;

  logic r_txd,     w_txd_nxt;
  logic r_busy,    w_busy_nxt;
  logic r_end,     w_end_nxt;
  logic r_aborted, w_aborted_nxt;

  logic             w_load;
  logic             w_run;
  logic             w_tick;
  logic [DIV_W-1:0] w_div_clamped;
  logic [7:0]       w_char;
  logic [2:0]       w_bit_sel;
  logic             w_next_bit;
  logic             w_parity;

  assign w_div_clamped = (DIVISOR == '0) ? DIV_W'(1) : DIVISOR;

  assign w_run = (r_state == ST_STARTB) || (r_state == ST_DATA) ||
                 (r_state == ST_PAR)    || (r_state == ST_STOP);

  serial_baud_tick #(
    .DIV_W (DIV_W)
  ) u_baud (
    .CLK      (CLK),
    .RESET    (RESET),
    .i_load   (w_load),
    .i_run    (w_run),
    .i_period (w_div_clamped),
    .o_tick   (w_tick)
  );

  // Character 0 occupies the most significant byte of the buffer; indices
  // past the payload select the CR LF trailer.
  always_comb begin
    w_char = CHR_LF;
    for (int k = 0; k < BUFFLEN; k++) begin
      if (r_chr == c_CHR_W'(k)) begin
        w_char = r_buf[8*(BUFFLEN-1-k) +: 8];
      end
    end
    if ((TRAILER != 0) && (r_chr == c_CHR_W'(BUFFLEN))) begin
      w_char = CHR_CR;
    end
  end

  // r_pos counts frame bits; while a data bit is on the line, r_pos[2:0]
  // already names the data bit that goes out next.
  assign w_bit_sel  = (LSB_FIRST != 0) ? r_pos[2:0] : (3'd7 - r_pos[2:0]);
  assign w_next_bit = w_char[w_bit_sel];
  assign w_parity   = (^w_char) ^ c_ODD_PAR;

  always_comb begin
    w_state_nxt   = r_state;
    w_pos_nxt     = r_pos;
    w_chr_nxt     = r_chr;
    w_txd_nxt     = r_txd;
    w_busy_nxt    = r_busy;
    w_end_nxt     = r_end;
    w_aborted_nxt = r_aborted;
    w_load        = 1'b0;

    if (w_run && ABORT) begin
      w_state_nxt   = ST_DONE;
      w_txd_nxt     = 1'b1;
      w_busy_nxt    = 1'b0;
      w_end_nxt     = 1'b1;
      w_aborted_nxt = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (START && !r_end) begin
            w_state_nxt   = ST_STARTB;
            w_pos_nxt     = '0;
            w_chr_nxt     = '0;
            w_txd_nxt     = 1'b0;
            w_busy_nxt    = 1'b1;
            w_aborted_nxt = 1'b0;
            w_load        = 1'b1;
          end
        end

        ST_STARTB: begin
          if (w_tick) begin
            w_state_nxt = ST_DATA;
            w_pos_nxt   = r_pos + 1'b1;
            w_txd_nxt   = w_next_bit;
          end
        end

        ST_DATA: begin
          if (w_tick) begin
            w_pos_nxt = r_pos + 1'b1;
            if (r_pos != c_LAST_DATA_POS) begin
              w_txd_nxt = w_next_bit;
            end else if (c_HAS_PAR) begin
              w_state_nxt = ST_PAR;
              w_txd_nxt   = w_parity;
            end else begin
              w_state_nxt = ST_STOP;
              w_txd_nxt   = 1'b1;
            end
          end
        end

        ST_PAR: begin
          if (w_tick) begin
            w_state_nxt = ST_STOP;
            w_pos_nxt   = r_pos + 1'b1;
            w_txd_nxt   = 1'b1;
          end
        end

        ST_STOP: begin
          if (w_tick) begin
            if (r_pos != c_LAST_POS) begin
              w_pos_nxt = r_pos + 1'b1;
            end else if (r_chr != c_LAST_CHR) begin
              // Back-to-back characters: next start bit follows immediately.
              w_state_nxt = ST_STARTB;
              w_pos_nxt   = '0;
              w_chr_nxt   = r_chr + 1'b1;
              w_txd_nxt   = 1'b0;
            end else begin
              w_state_nxt = ST_DONE;
              w_txd_nxt   = 1'b1;
              w_busy_nxt  = 1'b0;
              w_end_nxt   = 1'b1;
            end
          end
        end

        ST_DONE: begin
          if (!START) begin
            w_state_nxt = ST_IDLE;
            w_end_nxt   = 1'b0;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_txd_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_end_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= ST_IDLE;
      r_pos     <= '0;
      r_chr     <= '0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
      r_end     <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pos     <= w_pos_nxt;
      r_chr     <= w_chr_nxt;
      r_txd     <= w_txd_nxt;
      r_busy    <= w_busy_nxt;
      r_end     <= w_end_nxt;
      r_aborted <= w_aborted_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_buf <= '0;
    end else if (w_load) begin
      r_buf <= BUFFER;
    end
  end

  assign TXD     = r_txd;
  assign BUSY    = r_busy;
  assign END     = r_end;
  assign ABORTED = r_aborted;

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
// ============================================================================
//  tb_serial_frame_tx
//  Randomised self-checking bench for serial_frame_tx (three configurations).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_frame_tx;

  logic        CLK;
  logic        RESET;
  logic [2:0]  start;
  logic [2:0]  abort_req;
  logic [11:0] div  [3];
  logic [23:0] bufv [3];
  wire  [2:0]  txd, busy, endo, abtd;

  // Unit configurations: payload length, parity, stop bits, LSB first, trailer
  int cfg_len  [3] = '{1, 2, 3};
  int cfg_par  [3] = '{0, 1, 2};
  int cfg_stop [3] = '{1, 2, 2};
  int cfg_lsb  [3] = '{1, 1, 0};
  int cfg_trl  [3] = '{0, 0, 1};

  byte unsigned pay [3];
  bit           exp_q [$];
  int           n_checks = 0;
  int           n_fail   = 0;

  serial_frame_tx #(.BUFFLEN(1), .DIV_W(12), .PARITY(0), .STOP_BITS(1),
                    .LSB_FIRST(1), .TRAILER(0)) u_dut_a (
    .CLK(CLK), .RESET(RESET), .START(start[0]), .ABORT(abort_req[0]),
    .DIVISOR(div[0]), .BUFFER(bufv[0][7:0]),
    .TXD(txd[0]), .BUSY(busy[0]), .END(endo[0]), .ABORTED(abtd[0]));

  serial_frame_tx #(.BUFFLEN(2), .DIV_W(12), .PARITY(1), .STOP_BITS(2),
                    .LSB_FIRST(1), .TRAILER(0)) u_dut_b (
    .CLK(CLK), .RESET(RESET), .START(start[1]), .ABORT(abort_req[1]),
    .DIVISOR(div[1]), .BUFFER(bufv[1][15:0]),
    .TXD(txd[1]), .BUSY(busy[1]), .END(endo[1]), .ABORTED(abtd[1]));

  serial_frame_tx #(.BUFFLEN(3), .DIV_W(12), .PARITY(2), .STOP_BITS(2),
                    .LSB_FIRST(0), .TRAILER(1)) u_dut_c (
    .CLK(CLK), .RESET(RESET), .START(start[2]), .ABORT(abort_req[2]),
    .DIVISOR(div[2]), .BUFFER(bufv[2][23:0]),
    .TXD(txd[2]), .BUSY(busy[2]), .END(endo[2]), .ABORTED(abtd[2]));

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line-level model: the list of bit values a transfer must put on TXD.
  function automatic void build_expect(input int u);
    byte unsigned ch;
    bit           p;
    int           n;
    n = cfg_len[u] + 2 * cfg_trl[u];
    exp_q.delete();
    for (int c = 0; c < n; c++) begin
      if (c < cfg_len[u])       ch = pay[c];
      else if (c == cfg_len[u]) ch = 8'h0D;
      else                      ch = 8'h0A;
      exp_q.push_back(1'b0);
      for (int b = 0; b < 8; b++) exp_q.push_back(cfg_lsb[u] != 0 ? ch[b] : ch[7-b]);
      if (cfg_par[u] != 0) begin
        p = ($countones(ch) % 2) != 0;
        if (cfg_par[u] == 2) p = !p;
        exp_q.push_back(p);
      end
      for (int s = 0; s < cfg_stop[u]; s++) exp_q.push_back(1'b1);
    end
  endfunction

  // Big-endian position 8k+7-i holds bit i of character k; the vector is
  // declared descending, so position sp lands at index width-1-sp.
  task automatic load_inputs(input int u, input int d);
    int sp;
    bufv[u] = 24'($urandom);
    for (int k = 0; k < cfg_len[u]; k++) begin
      for (int i = 0; i < 8; i++) begin
        sp = 8 * k + 7 - i;
        bufv[u][8 * cfg_len[u] - 1 - sp] = pay[k][i];
      end
    end
    div[u] = 12'(d);
  endtask

  task automatic xfer(input int u, input int d, input int abort_at, input int hold);
    int w, len;
    bit aborted_now;
    aborted_now = 1'b0;
    load_inputs(u, d);
    build_expect(u);
    w   = ((d == 0) ? 1 : d) + 1;
    len = exp_q.size() * w;
    @(negedge CLK);
    start[u] = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(negedge CLK);
      check_eq("txd", txd[u], exp_q[i / w]);
      check_eq("busy", busy[u], 1);
      if (i == 0) begin
        check_eq("aborted_clear", abtd[u], 0);
        check_eq("end_low", endo[u], 0);
      end
      bufv[u] = 24'($urandom);
      div[u]  = 12'($urandom);
      if (i == abort_at) begin
        abort_req[u] = 1'b1;
        @(negedge CLK);
        abort_req[u] = 1'b0;
        check_eq("abort_txd", txd[u], 1);
        check_eq("abort_end", endo[u], 1);
        check_eq("abort_flag", abtd[u], 1);
        check_eq("abort_busy", busy[u], 0);
        aborted_now = 1'b1;
        break;
      end
    end
    if (!aborted_now) begin
      @(negedge CLK);
      check_eq("done_busy", busy[u], 0);
      check_eq("done_end", endo[u], 1);
      check_eq("done_txd", txd[u], 1);
      check_eq("done_aborted", abtd[u], 0);
    end
    repeat (hold) begin
      @(negedge CLK);
      check_eq("hold_txd", txd[u], 1);
      check_eq("hold_busy", busy[u], 0);
    end
    start[u] = 1'b0;
    @(negedge CLK);
    check_eq("end_release", endo[u], 0);
  endtask

  task automatic reset_mid(input int u, input int d, input int cycles);
    load_inputs(u, d);
    @(negedge CLK);
    start[u] = 1'b1;
    repeat (cycles) @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    check_eq("rst_txd", txd[u], 1);
    check_eq("rst_busy", busy[u], 0);
    check_eq("rst_end", endo[u], 0);
    start[u] = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  initial begin
    int u, d, ab;
    CLK       = 1'b0;
    RESET     = 1'b1;
    start     = '0;
    abort_req = '0;
    for (int i = 0; i < 3; i++) begin
      div[i]  = '0;
      bufv[i] = '0;
    end
    #1 RESET = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("reset_txd", txd[i], 1);
      check_eq("reset_busy", busy[i], 0);
      check_eq("reset_end", endo[i], 0);
      check_eq("reset_aborted", abtd[i], 0);
    end
    #20;
    @(negedge CLK);
    RESET = 1'b1;

    // Basic frame: 'H', divisor 3
    pay[0] = 8'h48;
    xfer(0, 3, -1, 0);
    // Even parity, two stop bits: "Hi"
    pay[0] = 8'h48; pay[1] = 8'h69;
    xfer(1, 1, -1, 0);
    // Odd parity, MSB first, CR LF trailer, clamped divisor 0
    pay[0] = 8'h48; pay[1] = 8'h69; pay[2] = 8'h21;
    xfer(2, 0, -1, 0);
    // START held long after END: no second transfer
    pay[0] = 8'h5A;
    xfer(0, 2, -1, 100);
    // Abort during the third data bit (bit width 3), then a clean transfer
    pay[0] = 8'hC3;
    xfer(0, 2, 3 * 3 + 1, 4);
    pay[0] = 8'h3C;
    xfer(0, 2, -1, 0);
    // Reset in the middle of character 1, then restart from character 0
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    reset_mid(2, 1, 30);
    xfer(2, 1, -1, 0);

    for (int r = 0; r < 12; r++) begin
      u = $urandom_range(0, 2);
      for (int k = 0; k < 3; k++) pay[k] = 8'($urandom);
      d  = $urandom_range(0, 4);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 19) : -1;
      xfer(u, d, ab, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
